// File: rtl/spad_pkg.sv
// Shared scratchpad definitions: controller states and frame-geometry helpers.
package spad_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } spad_state_e;

  function automatic int out_size(input int act, input int kern);
    return act - kern + 1;
  endfunction

  function automatic int win_size(input int kern);
    return kern * kern;
  endfunction

  function automatic int frame_size(input int act);
    return act * act;
  endfunction

endpackage

// File: rtl/spad_ram_1p.sv
// Single-port scratchpad RAM: synchronous write, registered read that holds when re is low.
module spad_ram_1p #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDR_BITWIDTH-1:0] addr,
  input  logic [DATA_BITWIDTH-1:0] wdata,
  output logic [DATA_BITWIDTH-1:0] rdata
);

  logic [DATA_BITWIDTH-1:0] mem [2**ADDR_BITWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spad_iact_window.sv
// Input-activation scratchpad: captures one A x A frame, then replays it as K x K
// convolution windows over a valid/ready handshake.
//
// state  | meaning
// LOAD   | accepting frame words from the router
// READY  | frame captured, waiting for start
// STREAM | issuing window reads and draining to the PE
module spad_iact_window
  import spad_pkg::*;
#(
  parameter int DATA_BITWIDTH      = 16,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int KERNEL_SIZE        = 3,
  parameter int ACT_SIZE           = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_BITWIDTH-1:0] w_data_spad,
  input  logic                     load_en_spad,
  input  logic                     start,
  output logic                     load_done,
  output logic                     busy,
  output logic [DATA_BITWIDTH-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     win_last,
  output logic                     frame_last
);

  localparam int AW    = ADDR_BITWIDTH_SPAD;
  localparam int O     = out_size(ACT_SIZE, KERNEL_SIZE);
  localparam int FRAME = frame_size(ACT_SIZE);
  localparam int CW    = (ACT_SIZE > 1) ? $clog2(ACT_SIZE) : 1;
  localparam logic [CW-1:0] K_MAX = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] O_MAX = CW'(O - 1);
  localparam logic [AW-1:0] A_W   = AW'(ACT_SIZE);
  localparam logic [AW-1:0] WR_LAST = AW'(FRAME - 1);

  if (FRAME > (1 << ADDR_BITWIDTH_SPAD) || KERNEL_SIZE > ACT_SIZE) begin : g_bad_cfg
    $error("spad_iact_window: frame exceeds spad depth or kernel exceeds activation");
  end

  spad_state_e state, state_next;
  logic [AW-1:0] wr_ptr, rd_addr, ram_addr, row, col;
  logic [CW-1:0] kx, ky, ox, oy;
  logic [DATA_BITWIDTH-1:0] ram_rdata;
  logic wr_en, issue, fin, out_adv, cur_win, cur_frame;
  logic issue_done, s1_valid, s1_win, s1_frame;

  assign row       = AW'(oy) + AW'(ky);
  assign col       = AW'(ox) + AW'(kx);
  assign rd_addr   = row * A_W + col;
  assign ram_addr  = (state == LOAD) ? wr_ptr : rd_addr;
  assign cur_win   = (kx == K_MAX) && (ky == K_MAX);
  assign cur_frame = cur_win && (ox == O_MAX) && (oy == O_MAX);
  assign out_adv   = !rd_valid || rd_ready;

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    issue      = 1'b0;
    fin        = 1'b0;
    case (state)
      LOAD: begin
        if (load_en_spad) begin
          wr_en = 1'b1;
          if (wr_ptr == WR_LAST) state_next = READY;
        end
      end
      READY: begin
        // First read goes out with start so the word reaches the PE two cycles later.
        if (start) begin
          issue      = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        issue = !issue_done && (!s1_valid || out_adv);
        if (rd_valid && rd_ready && frame_last) begin
          fin        = 1'b1;
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      kx         <= '0;
      ky         <= '0;
      ox         <= '0;
      oy         <= '0;
      issue_done <= 1'b0;
      s1_valid   <= 1'b0;
      s1_win     <= 1'b0;
      s1_frame   <= 1'b0;
      load_done  <= 1'b0;
      busy       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      win_last   <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      state <= state_next;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (wr_en && wr_ptr == WR_LAST) load_done <= 1'b1;
      if (state == READY && start) busy <= 1'b1;
      if (issue) begin
        s1_win   <= cur_win;
        s1_frame <= cur_frame;
        if (cur_frame) issue_done <= 1'b1;
        if (kx != K_MAX) kx <= kx + CW'(1);
        else begin
          kx <= '0;
          if (ky != K_MAX) ky <= ky + CW'(1);
          else begin
            ky <= '0;
            if (ox != O_MAX) ox <= ox + CW'(1);
            else begin
              ox <= '0;
              oy <= (oy != O_MAX) ? oy + CW'(1) : '0;
            end
          end
        end
      end
      // RAM output holds while re is low, so it doubles as the skid stage.
      if (issue) s1_valid <= 1'b1;
      else if (out_adv) s1_valid <= 1'b0;
      if (out_adv) begin
        rd_valid   <= s1_valid;
        rd_data    <= s1_valid ? ram_rdata : '0;
        win_last   <= s1_valid && s1_win;
        frame_last <= s1_valid && s1_frame;
      end
      if (fin) begin
        wr_ptr     <= '0;
        load_done  <= 1'b0;
        busy       <= 1'b0;
        issue_done <= 1'b0;
      end
    end
  end

  spad_ram_1p #(
    .DATA_BITWIDTH(DATA_BITWIDTH),
    .ADDR_BITWIDTH(ADDR_BITWIDTH_SPAD)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .re   (issue),
    .addr (ram_addr),
    .wdata(w_data_spad),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_spad_iact_window.sv
// Self-checking bench for spad_iact_window: window-order model plus random data and backpressure.
module tb_spad_iact_window;

  localparam int DW = 16, AW = 9, K = 3, A = 5;
  localparam int O = A - K + 1, FRAME = A * A, TOTAL = O * O * K * K;

  logic clk = 1'b0;
  logic reset, load_en_spad, start, rd_ready;
  logic [DW-1:0] w_data_spad, rd_data;
  logic load_done, busy, rd_valid, win_last, frame_last;

  int vec = 0, errs = 0;
  int mem_m [FRAME];
  int exp_data [TOTAL];
  bit exp_win [TOTAL];
  bit exp_frame [TOTAL];

  always #5 clk = ~clk;

  spad_iact_window #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH_SPAD(AW), .KERNEL_SIZE(K), .ACT_SIZE(A)
  ) dut (
    .clk(clk), .reset(reset), .w_data_spad(w_data_spad), .load_en_spad(load_en_spad),
    .start(start), .load_done(load_done), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .win_last(win_last), .frame_last(frame_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stream straight from the window definition: output position major, kernel minor.
  task automatic build_exp();
    for (int oy = 0; oy < O; oy++)
      for (int ox = 0; ox < O; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            int i;
            i = ((oy * O + ox) * K + ky) * K + kx;
            exp_data[i]  = mem_m[(oy + ky) * A + ox + kx];
            exp_win[i]   = (kx == K - 1) && (ky == K - 1);
            exp_frame[i] = exp_win[i] && (ox == O - 1) && (oy == O - 1);
          end
  endtask

  task automatic load_frame(input bit rnd);
    for (int i = 0; i < FRAME; i++) begin
      mem_m[i] = rnd ? int'($urandom_range(0, 16'hFFFF)) : i;
      load_en_spad = 1'b1;
      w_data_spad  = DW'(mem_m[i]);
      tick();
      if (i == FRAME - 2) chk("load_done_early", {31'd0, load_done}, 32'd0);
      chk("no_valid_in_load", {31'd0, rd_valid}, 32'd0);
    end
    load_en_spad = 1'b0;
    chk("load_done", {31'd0, load_done}, 32'd1);
    build_exp();
  endtask

  // stop_at >= 0 applies reset when that many words have been accepted.
  task automatic run_stream(input bit rnd, input int stop_at);
    int idx;
    bit done, held;
    logic [DW-1:0] h_data;
    logic h_win, h_frame;
    idx = 0; done = 0; held = 0;
    h_data = '0; h_win = 0; h_frame = 0;
    rd_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("valid_at_n1", {31'd0, rd_valid}, 32'd0);
    tick();
    chk("valid_at_n2", {31'd0, rd_valid}, 32'd1);
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      if (stop_at >= 0 && idx == stop_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_outputs", {10'd0, load_done, busy, rd_valid, win_last, frame_last, 1'b0, rd_data}, 32'd0);
        return;
      end
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held = 0;
      if (rd_valid && rd_ready) begin
        if (idx >= TOTAL) begin
          chk("overrun", idx, TOTAL - 1);
          done = 1;
        end else begin
          chk("rd_data", {16'd0, rd_data}, exp_data[idx]);
          chk("win_last", {31'd0, win_last}, {31'd0, exp_win[idx]});
          chk("frame_last", {31'd0, frame_last}, {31'd0, exp_frame[idx]});
          idx++;
        end
      end else if (rd_valid) begin
        held = 1; h_data = rd_data; h_win = win_last; h_frame = frame_last;
      end else begin
        chk("no_bubble", {31'd0, rd_valid}, 32'd1);
      end
      tick();
      if (held) begin
        chk("stall_valid", {31'd0, rd_valid}, 32'd1);
        chk("stall_data", {16'd0, rd_data}, {16'd0, h_data});
        chk("stall_flags", {30'd0, win_last, frame_last}, {30'd0, h_win, h_frame});
      end
      if (idx == TOTAL && !done) begin
        chk("valid_drop", {31'd0, rd_valid}, 32'd0);
        chk("busy_drop", {31'd0, busy}, 32'd0);
        chk("load_done_clr", {31'd0, load_done}, 32'd0);
        done = 1;
      end
    end
    if (!done) chk("stream_timeout", 32'd0, 32'd1);
    chk("word_count", idx, TOTAL);
  endtask

  initial begin
    reset = 1'b1; load_en_spad = 1'b0; start = 1'b0; rd_ready = 1'b1; w_data_spad = '0;
    tick();
    tick();
    chk("reset_state", {10'd0, load_done, busy, rd_valid, win_last, frame_last, 1'b0, rd_data}, 32'd0);
    reset = 1'b0;

    load_frame(1'b0);
    run_stream(1'b0, -1);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_load_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("start_in_load_valid", {31'd0, rd_valid}, 32'd0);

    load_frame(1'b0);
    load_en_spad = 1'b1;
    w_data_spad = 16'd99;
    tick();
    load_en_spad = 1'b0;
    chk("ready_extra_word", {31'd0, load_done}, 32'd1);
    run_stream(1'b1, -1);

    load_frame(1'b1);
    run_stream(1'b1, -1);

    load_frame(1'b0);
    run_stream(1'b0, 39);
    load_frame(1'b0);
    run_stream(1'b0, -1);

    load_frame(1'b1);
    run_stream(1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/spad_iact_window.md
# spad_iact_window

Input-activation scratchpad with sliding-window read-out for one PE. It captures the activation frame streamed in by the GLB-to-spad iact router (`w_data_spad` / `load_en_spad`). On command, it replays the stored frame as kernel-sized convolution windows to the PE MAC over a valid/ready handshake. It sits directly downstream of the iact router and upstream of the PE datapath.

## Interface
- `DATA_BITWIDTH`, 16: activation word width.
- `ADDR_BITWIDTH_SPAD`, 9: spad address width; depth = 2^ADDR_BITWIDTH_SPAD.
- `KERNEL_SIZE`, 3: square kernel edge K.
- `ACT_SIZE`, 5: square activation edge A. Elaboration error if A*A > depth or K > A.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `w_data_spad`, in, DATA_BITWIDTH: write data from router.
- `load_en_spad`, in, 1: write strobe; one word per high cycle.
- `start`, in, 1: begin window stream; single-cycle pulse.
- `load_done`, out, 1: frame fully captured.
- `busy`, out, 1: streaming in progress.
- `rd_data`, out, DATA_BITWIDTH: activation to PE.
- `rd_valid`, out, 1: `rd_data` valid.
- `rd_ready`, in, 1: PE accepts the word.
- `win_last`, out, 1: current word is the last of a K*K window.
- `frame_last`, out, 1: current word is the last of the whole stream.

## Operation
- Derived values: O = A-K+1; WIN = K*K; FRAME = A*A. Total stream length = O*O*WIN (81 for the defaults).
- State LOAD (the reset state):
  - Each cycle with `load_en_spad`=1 writes `w_data_spad` to `wr_ptr`, then increments `wr_ptr`.
  - After the FRAME-th write, go to READY and set `load_done`=1.
- State READY:
  - `load_en_spad` is ignored; extra words are dropped and memory is unchanged.
  - `start`=1 moves to STREAM, sets `busy`=1 and clears the counters ox, oy, kx, ky.
- State STREAM:
  - Read address = (oy+ky)*A + (ox+kx).
  - Counter order: kx fastest, then ky, then ox, then oy.
  - Counters advance only when a word is issued into the output register.
  - The word with kx=ky=K-1 carries `win_last`=1. If ox=oy=O-1 as well, it also carries `frame_last`=1.
  - After the `frame_last` word handshakes (`rd_valid` && `rd_ready`):
    - Go to LOAD.
    - Clear `wr_ptr`, `load_done` and `busy`.
- `start` outside READY is ignored. `load_en_spad` outside LOAD is ignored.
- Address arithmetic is done at ADDR_BITWIDTH_SPAD width. Counters are sized by $clog2(A) and never wrap mid-frame.

## Timing
- Reset values: `load_done`=0, `busy`=0, `rd_valid`=0, `rd_data`=0, `win_last`=0, `frame_last`=0. Internal: state LOAD, `wr_ptr`=0, all counters 0.
- Memory has 1-cycle registered read latency. Output register is the stage after it.
- `load_done` rises the cycle after the FRAME-th write strobe.
- `start` is sampled in cycle N. The first `rd_valid` is asserted in cycle N+2.
- With `rd_ready` held high, one word is transferred per cycle with no bubbles.
- Backpressure: while `rd_valid`=1 and `rd_ready`=0:
  - `rd_data`, `win_last` and `frame_last` hold stable.
  - Address generation stalls; no word is lost or duplicated.
  - A skid register or read-enable gating covers the in-flight read.
- `rd_valid` falls the cycle after the `frame_last` handshake. `busy` falls in the same cycle.
- A new `load_en_spad` is accepted from the cycle after the return to LOAD.
- Reset mid-operation (any state): all outputs return to reset values next cycle. Memory contents are don't-care, and a fresh load is required.

## Structure
- Shared package `spad_pkg` holds:
  - The state enum {LOAD, READY, STREAM}.
  - Helper functions for O, WIN and FRAME.
  - Shared with the weight spad.
- Sub-module `spad_ram_1p`: single-port, synchronous write, registered read, DATA_BITWIDTH x 2^ADDR_BITWIDTH_SPAD.
  - Single-port is sufficient because writes occur only in LOAD and reads only in STREAM.
- Top level contains the FSM, write pointer, window counters, address multiply-add and output/skid register.

## Test plan
- Load words 0..24 on 25 consecutive cycles -> `load_done`=1 the cycle after the 25th strobe; no `rd_valid`.
- Pulse `start` with `rd_ready`=1 -> first window is 0,1,2,5,6,7,10,11,12, with `win_last` on 12; the first word appears 2 cycles after `start`.
- Continue streaming -> 81 words total; last window is 12,13,14,17,18,19,22,23,24; `frame_last` on 24; `busy` drops the same cycle `rd_valid` drops.
- Toggle `rd_ready` pseudo-randomly across the full stream -> the accepted sequence is identical to the no-stall run and outputs are stable while stalled.
- Write a 26th word (value 99) in READY, then stream -> 99 never appears; `start` pulsed in LOAD is ignored (`busy` stays 0).
- Assert `reset` at the 40th streamed word -> next cycle all outputs are 0; a reload of 0..24 plus `start` reproduces the full 81-word sequence.
